// File: rtl/change_dispenser_if.sv
`timescale 1ns/1ps
// Purpose : request, coin-hopper and inventory signals of the change dispenser.
// Ports   : slave = dispenser side, master = requester/hopper/refill side.
// Payload : req/amount/ready/done/fault, coin/coin_valid/coin_ack, refill5/10, cnt5/10.
interface change_dispenser_if #(
  parameter int AMT_W = 5,
  parameter int CNT_W = 6
);
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             ready;
  logic [1:0]       coin;
  logic             coin_valid;
  logic             coin_ack;
  logic             done;
  logic             fault;
  logic             refill5;
  logic             refill10;
  logic [CNT_W-1:0] cnt5;
  logic [CNT_W-1:0] cnt10;

  modport master (
    output req, amount, coin_ack, refill5, refill10,
    input  ready, coin, coin_valid, done, fault, cnt5, cnt10
  );

  modport slave (
    input  req, amount, coin_ack, refill5, refill10,
    output ready, coin, coin_valid, done, fault, cnt5, cnt10
  );
endinterface

// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
// Purpose : pays a change amount out as 10-unit/5-unit coins from tracked inventory.
// Latency : first coin presented the cycle after req is accepted; one 00 gap cycle between coins.
// Backpr. : a presented coin is held stable until coin_ack; req is only taken while ready.
// Ports   : clk, rst (sync, active-low); bus (slave modport) carries request, coin
//           handshake, refill strobes and inventory counts.
module change_dispenser #(
  parameter int AMT_W  = 5,
  parameter int CNT_W  = 6,
  parameter int INIT5  = 8,
  parameter int INIT10 = 8
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   bus
);

  // Wide enough to hold either an amount or a count, plus headroom for 2*n10.
  localparam int W = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    st_idle,
    st_present,
    st_gap,
    st_done,
    st_fault
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] rem_next;
  logic [AMT_W-1:0] step_amt;
  // Coin choice is frozen when a coin is first presented so that a refill
  // during a hopper stall cannot change the coin on the wire.
  logic             pick10;
  logic [CNT_W-1:0] cnt5_q, cnt10_q;
  logic             dec5, dec10;

  // Feasibility: use as many 10s as possible, the rest must be covered by 5s.
  logic [W-1:0] half, n10, need5;
  logic         feasible;

  always_comb begin
    half     = W'(bus.amount >> 1);
    n10      = (W'(cnt10_q) < half) ? W'(cnt10_q) : half;
    need5    = W'(bus.amount) - (n10 << 1);
    feasible = (W'(cnt5_q) >= need5);
  end

  assign step_amt = pick10 ? AMT_W'(2) : AMT_W'(1);
  assign rem_next = remaining - step_amt;

  assign dec10 = (state_q == st_present) && bus.coin_ack &&  pick10;
  assign dec5  = (state_q == st_present) && bus.coin_ack && !pick10;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= st_idle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      st_idle: begin
        if (bus.req) begin
          if (bus.amount == '0) state_d = st_done;
          else if (!feasible)   state_d = st_fault;
          else                  state_d = st_present;
        end
      end
      st_present: begin
        if (bus.coin_ack) state_d = (rem_next == '0) ? st_done : st_gap;
      end
      st_gap:   state_d = st_present;
      st_done:  state_d = st_idle;
      st_fault: state_d = st_idle;
      default:  state_d = st_idle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.ready      = (state_q == st_idle);
    bus.coin_valid = (state_q == st_present);
    bus.coin       = 2'b00;
    if (state_q == st_present) bus.coin = pick10 ? 2'b10 : 2'b01;
    bus.done       = (state_q == st_done);
    bus.fault      = (state_q == st_fault);
  end

  // Payout datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining <= '0;
      pick10    <= 1'b0;
    end else begin
      case (state_q)
        st_idle: begin
          if (bus.req) begin
            remaining <= bus.amount;
            pick10    <= (bus.amount >= AMT_W'(2)) && (cnt10_q != '0);
          end
        end
        st_present: begin
          if (bus.coin_ack) remaining <= rem_next;
        end
        // Counts already reflect the previous coin here.
        st_gap: pick10 <= (remaining >= AMT_W'(2)) && (cnt10_q != '0);
        default: ;
      endcase
    end
  end

  // Inventory: refill and dispense of the same coin in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt5_q  <= CNT_W'(INIT5);
      cnt10_q <= CNT_W'(INIT10);
    end else begin
      if (bus.refill5 && !dec5) begin
        if (cnt5_q != CNT_MAX) cnt5_q <= cnt5_q + 1'b1;
      end else if (dec5 && !bus.refill5) begin
        cnt5_q <= cnt5_q - 1'b1;
      end

      if (bus.refill10 && !dec10) begin
        if (cnt10_q != CNT_MAX) cnt10_q <= cnt10_q + 1'b1;
      end else if (dec10 && !bus.refill10) begin
        cnt10_q <= cnt10_q - 1'b1;
      end
    end
  end

  assign bus.cnt5  = cnt5_q;
  assign bus.cnt10 = cnt10_q;

endmodule

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
// Bench for change_dispenser: directed requests, a coin-list model built from
// the greedy rule, and a per-cycle compare against that model.
module tb_change_dispenser;
  localparam int AMT_W  = 5;
  localparam int CNT_W  = 6;
  localparam int INIT5  = 8;
  localparam int INIT10 = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

  change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT5(INIT5), .INIT10(INIT10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // phase: 0 waiting, 1 coin on the wire, 2 spacer, 3 done pulse, 4 fault pulse
  int       m5, m10, phase;
  int       d5, d10, a, n10;
  bit [1:0] q[$];
  bit       mon_on = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m5 = INIT5; m10 = INIT10; phase = 0; q.delete();
    end else begin
      d5 = 0; d10 = 0;
      case (phase)
        0: if (bus.req) begin
          a   = int'(bus.amount);
          n10 = (m10 < a / 2) ? m10 : a / 2;
          if (a == 0)                 phase = 3;
          else if (m5 < a - 2 * n10)  phase = 4;
          else begin
            q.delete();
            repeat (n10)         q.push_back(2'b10);
            repeat (a - 2 * n10) q.push_back(2'b01);
            phase = 1;
          end
        end
        1: if (bus.coin_ack) begin
          if (q[0] == 2'b10) d10 = 1; else d5 = 1;
          void'(q.pop_front());
          phase = (q.size() == 0) ? 3 : 2;
        end
        2: phase = 1;
        default: phase = 0;
      endcase
      m5  = m5  + int'(bus.refill5)  - d5;
      m10 = m10 + int'(bus.refill10) - d10;
      if (m5  > MAXC) m5  = MAXC;
      if (m10 > MAXC) m10 = MAXC;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("ready",      int'(bus.ready),      int'(phase == 0));
      chk("coin_valid", int'(bus.coin_valid), int'(phase == 1));
      chk("coin",       int'(bus.coin),       (phase == 1) ? int'(q[0]) : 0);
      chk("done",       int'(bus.done),       int'(phase == 3));
      chk("fault",      int'(bus.fault),      int'(phase == 4));
      chk("cnt5",       int'(bus.cnt5),       m5);
      chk("cnt10",      int'(bus.cnt10),      m10);
      chk("done_and_fault", int'(bus.done & bus.fault), 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic request(input int amt);
    bus.amount = AMT_W'(amt);
    bus.req    = 1'b1;
    @(posedge clk); #1;
    bus.req    = 1'b0;
  endtask

  // Counts negedges before the selected pulse (0 = done, 1 = fault) shows up.
  task automatic wait_pulse(input int which, output int cyc);
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc <= 100) begin
      @(negedge clk);
      if ((which == 0 && bus.done) || (which == 1 && bus.fault)) seen = 1'b1;
      else cyc++;
    end
    if (!seen) chk("pulse_timeout", 0, 1);
  endtask

  task automatic settle_and_check(input string tag, input int e5, input int e10);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_ready"}, int'(bus.ready), 1);
    chk({tag, "_cnt5"},  int'(bus.cnt5),  e5);
    chk({tag, "_cnt10"}, int'(bus.cnt10), e10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected end");
    $fatal(1, "watchdog");
  end

  int cyc;

  initial begin
    bus.req = 1'b0; bus.amount = '0; bus.coin_ack = 1'b0;
    bus.refill5 = 1'b0; bus.refill10 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready",  int'(bus.ready), 1);
    chk("rst_valid",  int'(bus.coin_valid), 0);
    chk("rst_cnt5",   int'(bus.cnt5), 8);
    chk("rst_cnt10",  int'(bus.cnt10), 8);

    // 1: amount 3, ack tied high -> 10, gap, 01, done
    bus.coin_ack = 1'b1;
    request(3);
    wait_pulse(0, cyc);
    chk("t1_done_latency", cyc, 3);
    settle_and_check("t1", 7, 7);

    // drain tens to 1: amount 12 -> six 10s
    request(12);
    wait_pulse(0, cyc);
    settle_and_check("prep2", 7, 1);

    // 2: amount 4 with one 10 left -> 10, 01, 01
    request(4);
    wait_pulse(0, cyc);
    chk("t2_done_latency", cyc, 5);
    settle_and_check("t2", 5, 0);

    // 3: amount 0 -> immediate done, no coins
    request(0);
    wait_pulse(0, cyc);
    chk("t3_done_latency", cyc, 0);
    settle_and_check("t3", 5, 0);

    // drain fives to 2: amount 3 with no 10s -> three 01
    request(3);
    wait_pulse(0, cyc);
    settle_and_check("prep4", 2, 0);

    // 4: amount 3 needs three 5s but only two -> fault
    request(3);
    wait_pulse(1, cyc);
    chk("t4_fault_latency", cyc, 0);
    settle_and_check("t4", 2, 0);

    // back to initial inventory
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_cnt5",  int'(bus.cnt5), 8);
    chk("rst2_cnt10", int'(bus.cnt10), 8);

    // 5: amount 2, hopper stalls 5 cycles; stray req ignored; refill10 on ack
    bus.coin_ack = 1'b0;
    request(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_coin",  int'(bus.coin), 2);
      chk("t5_valid", int'(bus.coin_valid), 1);
      if (i == 1) begin bus.amount = AMT_W'(7); bus.req = 1'b1; end
      if (i == 2) bus.req = 1'b0;
    end
    bus.coin_ack = 1'b1;
    bus.refill10 = 1'b1;
    @(posedge clk); #1;
    bus.coin_ack = 1'b0;
    bus.refill10 = 1'b0;
    @(negedge clk);
    chk("t5_done",  int'(bus.done), 1);
    chk("t5_cnt10", int'(bus.cnt10), 8);
    settle_and_check("t5", 8, 8);
    @(negedge clk);
    chk("t5_no_second_payout", int'(bus.coin_valid), 0);

    // refill saturation: 8 + 60 clamps at the counter maximum
    bus.refill5 = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    bus.refill5 = 1'b0;
    @(negedge clk);
    chk("sat_cnt5", int'(bus.cnt5), 63);

    // 6: amount 5, reset right after the first ack drops the payout
    bus.coin_ack = 1'b1;
    request(5);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", int'(bus.coin_valid), 0);
    chk("t6_coin",  int'(bus.coin), 0);
    chk("t6_ready", int'(bus.ready), 1);
    chk("t6_cnt10", int'(bus.cnt10), 8);
    chk("t6_cnt5",  int'(bus.cnt5), 8);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_done", int'(bus.done), 0);
      @(negedge clk);
    end
    bus.coin_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout side of the ticket vending machine. The vending machine accepts coins on a 2-bit coin code; this block pays coins back out on the same code.
- Takes a change amount, checks it against on-board coin inventory, and emits coins one at a time on coin[1:0] with a valid/ack handshake to the coin hopper.
- Tracks 5-unit and 10-unit coin counts, including refills.

Parameters:
- AMT_W, 5, width of requested amount in 5-unit steps (amount 3 = 15).
- CNT_W, 6, width of each inventory counter; counters saturate at 2^CNT_W-1.
- INIT5, 8, 5-unit coin count loaded on reset.
- INIT10, 8, 10-unit coin count loaded on reset.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  1  change request; sampled only while ready=1.
- amount  in  AMT_W  change to pay, in 5-unit steps.
- ready  out  1  high in IDLE only.
- coin  out  2  coin code: 2'b01 = 5-unit, 2'b10 = 10-unit, 2'b00 = none.
- coin_valid  out  1  coin is presented to the hopper.
- coin_ack  in  1  hopper accepted the presented coin.
- done  out  1  one-cycle pulse; payout complete.
- fault  out  1  one-cycle pulse; request rejected for insufficient inventory.
- refill5  in  1  add one 5-unit coin to inventory.
- refill10  in  1  add one 10-unit coin to inventory.
- cnt5  out  CNT_W  current 5-unit inventory.
- cnt10  out  CNT_W  current 10-unit inventory.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, remaining=0, coin=00, coin_valid=0, done=0, fault=0, ready=1.
  - cnt5=INIT5, cnt10=INIT10.
  - Reset overrides all activity, including a payout mid-dispense; that payout is lost.
- States: IDLE, PRESENT, GAP, DONE, FAULT.
- IDLE:
  - ready=1. On req=1, latch amount into remaining.
  - Feasibility uses registered counts: n10 = min(cnt10, amount/2); feasible iff cnt5 >= amount - 2*n10.
  - amount=0 -> DONE. Infeasible -> FAULT. Otherwise -> PRESENT.
  - req while ready=0 is ignored; no queueing.
- PRESENT:
  - coin_valid=1.
  - coin=10 if remaining>=2 and cnt10>0, else coin=01.
  - coin and coin_valid stay stable until coin_ack=1, however long the stall.
  - On coin_valid&coin_ack, remaining decreases by 2 (coin 10) or 1 (coin 01), and the matching counter decreases by 1.
  - If the new remaining is 0 -> DONE, else -> GAP.
  - coin_ack outside PRESENT is ignored.
- GAP:
  - Exactly one cycle with coin=00 and coin_valid=0, then -> PRESENT.
  - Gives the receiving side a 00 cycle between coins.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: fault=1 for one cycle, no coin emitted, counts unchanged, then IDLE.
- Latency:
  - req accepted at edge N gives coin_valid=1 in the cycle after edge N.
  - With ack held high, coins arrive every 2 cycles.
  - done asserts the cycle after the final ack.
- Inventory updates:
  - refill5/refill10 apply in any state, +1 per cycle, saturating at max.
  - Refill and dispense-decrement of the same counter in the same cycle leave it unchanged.
  - A refill in the same cycle as req is not counted in that request's feasibility check.
- Greedy selection always succeeds once the feasibility check passes; no underflow is possible.
- done and fault are never high together. ready=0 in every state except IDLE.

Test Plan:
1. Reset, amount=3, req=1, coin_ack tied high -> coins 10, (gap 00), 01; done 1 cycle after second ack; cnt10=7, cnt5=7, ready=1.
2. Preload cnt10=1 via reset with INIT10=1, amount=4 -> coins 10, 01, 01; done; cnt10=0, cnt5=6.
3. amount=0 -> no coin_valid; done pulses in the cycle after acceptance; counts unchanged.
4. INIT10=0, INIT5=2, amount=3 -> fault pulses 1 cycle, coin_valid never high, cnt5=2, ready=1 the cycle after.
5. amount=2, hold coin_ack=0 for 5 cycles -> coin=10 and coin_valid=1 stable throughout. During the stall:
   - req with amount=7 is ignored.
   - refill10 pulsed in the ack cycle -> cnt10 stays 8.
   - done follows the ack.
6. amount=5, drive rst=0 after the first ack -> next edge: coin_valid=0, coin=00, ready=1, cnt10=INIT10, cnt5=INIT5, no done pulse.
